hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline hazard scheduler that sits beside the forwarding unit. It decides which stage registers stall or flush.
//  Hazards covered: load-use, JALR source dependency (JALR resolves in ID), taken-branch redirect from EX,
//  and multi-cycle (mul/div) occupancy of EX. A handshake FSM sequences the multi-cycle unit and guards it with a timeout.
// PARAMETERS
//  MC_TIMEOUT  64  max cycles in MC_WAIT before forced release (>=2)
//  PERF_W      32  width of perf counters (HAZ_PERF_EN only)
// PORTS
//  clk            in   1  pipeline clock, rising edge
//  rst_n          in   1  asynchronous active-low reset
//  id_rs1,id_rs2  in   5  source regs of instruction in ID
//  id_use_rs1/2   in   1  ID instruction actually reads rs1/rs2
//  id_is_jalr     in   1  ID holds JALR (needs rs1 in ID)
//  ex_rd          in   5  dest reg of instruction in EX (ID/EX)
//  ex_mem_read    in   1  EX instruction is a load
//  ex_reg_write   in   1  EX instruction writes rd
//  mem_rd         in   5  dest reg in MEM (EX/MEM)
//  mem_mem_read   in   1  MEM instruction is a load
//  ex_br_taken    in   1  branch in EX resolved taken (redirect this cycle)
//  id_jump        in   1  JAL/JALR redirect from ID this cycle
//  ex_mc_req      in   1  EX holds a multi-cycle op
//  mc_done        in   1  multi-cycle unit result valid (1 cycle)
//  pc_stall,if_id_stall,id_ex_stall  out 1  hold register
//  if_id_flush,id_ex_flush           out 1  load bubble (NOP)
//  ex_mem_bubble  out  1  write NOP into EX/MEM
//  mc_start       out  1  1-cycle start pulse to multi-cycle unit
//  mc_err         out  1  sticky: timeout occurred
//  perf_stall_cyc,perf_flush_cnt out PERF_W  perf counters
// BEHAVIOUR
//  Reset: all outputs 0, state RUN, counters 0; reset mid-MC_WAIT aborts silently, no mc_start/err.
//  Hazard terms (combinational, valid only in RUN; x!=0 required for every reg match):
//   LU = ex_mem_read & (id_use_rs1&id_rs1==ex_rd | id_use_rs2&id_rs2==ex_rd)
//   JH = id_is_jalr & (ex_reg_write&id_rs1==ex_rd | mem_mem_read&id_rs1==mem_rd)
//   JALR after ALU op: JH stalls 1 cycle (no ID-stage EX result); after load: 2 cycles (JH rearms via mem term).
//  Priority in RUN, highest first:
//   1 ex_br_taken: if_id_flush=1,id_ex_flush=1; LU/JH/id_jump/ex_mc_req ignored that cycle.
//   2 ex_mc_req: mc_start=1, pc/if_id/id_ex stall=1, ex_mem_bubble=1, next MC_WAIT, cnt<=1.
//   3 LU|JH: pc_stall=1, if_id_stall=1, id_ex_flush=1.
//   4 id_jump: if_id_flush=1.
//  FSM: RUN -> MC_WAIT (rule 2).
//   MC_WAIT: pc/if_id/id_ex stall=1, ex_mem_bubble=1, cnt++ each cycle.
//   MC_WAIT & mc_done: that cycle stalls=0, ex_mem_bubble=0 (result latched into EX/MEM this edge) -> RUN.
//   MC_WAIT & !mc_done & cnt==MC_TIMEOUT: same release as done, mc_err<=1 (sticky to reset) -> RUN.
//   mc_done in RUN ignored; min mc latency 1 cycle after mc_start. Back-to-back mc ops: RUN re-arms next cycle.
//   ex_br_taken, id_jump and LU ignored in MC_WAIT (EX holds mc op, front end frozen).
//  Stall and flush never both 1 on same register; cnt width clog2(MC_TIMEOUT+1), no wrap.
// CONFIGURATION
//  HAZ_PERF_EN defined:
//   perf_stall_cyc +1 every cycle pc_stall=1.
//   perf_flush_cnt +1 every cycle if_id_flush|id_ex_flush=1.
//   Both saturate at all-ones; reset to 0.
//  Not defined: counters absent, perf outputs tied 0.
// TESTING
//  T1 ex lw x5, id add x6,x5,x1 -> 1 cycle pc_stall=if_id_stall=id_ex_flush=1, then all 0.
//  T2 ex lw x5, id jalr x5 -> 2 stall cycles; ex addi x5 then jalr x5 -> 1 stall cycle.
//  T3 ex_mc_req=1, mc_done 4 cycles after start -> mc_start 1 cycle; stalls+bubble 4 cycles; released in done cycle.
//  T4 MC_TIMEOUT=8, no mc_done -> release after 8 cycles, mc_err=1 until rst_n=0.
//  T5 ex_br_taken=1 with LU=1 and id_jump=1 -> only if_id_flush=id_ex_flush=1, pc_stall=0.
//  T6 rst_n low mid-MC_WAIT -> outputs 0 immediately (async), RUN; with HAZ_PERF_EN counters 0; T1 gives stall=1,flush=1.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - hazard scheduler bus between pipeline and stall controller
// Purpose: bundles the ID/EX/MEM hazard inputs and the stall/flush/multi-cycle
//          control outputs of hazard_stall_ctrl.
// Modports:
//   slave  - the controller: hazard inputs in, stall/flush/mc/perf outputs out
//   master - the pipeline side: drives hazard inputs, observes controls
// Parameter PERF_W sizes the perf counter outputs (only counting with HAZ_PERF_EN).
interface hazard_stall_ctrl_if #(
   parameter int PERF_W = 32
);
   logic [4:0]        id_rs1;
   logic [4:0]        id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic              id_is_jalr;
   logic [4:0]        ex_rd;
   logic              ex_mem_read;
   logic              ex_reg_write;
   logic [4:0]        mem_rd;
   logic              mem_mem_read;
   logic              ex_br_taken;
   logic              id_jump;
   logic              ex_mc_req;
   logic              mc_done;
   logic              pc_stall;
   logic              if_id_stall;
   logic              id_ex_stall;
   logic              if_id_flush;
   logic              id_ex_flush;
   logic              ex_mem_bubble;
   logic              mc_start;
   logic              mc_err;
   logic [PERF_W-1:0] perf_stall_cyc;
   logic [PERF_W-1:0] perf_flush_cnt;

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_jalr,
             ex_rd, ex_mem_read, ex_reg_write, mem_rd, mem_mem_read,
             ex_br_taken, id_jump, ex_mc_req, mc_done,
      output pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
             ex_mem_bubble, mc_start, mc_err, perf_stall_cyc, perf_flush_cnt
   );

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_jalr,
             ex_rd, ex_mem_read, ex_reg_write, mem_rd, mem_mem_read,
             ex_br_taken, id_jump, ex_mc_req, mc_done,
      input  pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
             ex_mem_bubble, mc_start, mc_err, perf_stall_cyc, perf_flush_cnt
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard stall/flush scheduler with multi-cycle handshake
// Purpose: decides stall/flush of PC, IF/ID, ID/EX and bubbling of EX/MEM for
//          load-use, JALR-in-ID dependency, taken branch redirect and mul/div
//          occupancy; sequences the multi-cycle unit with a timeout guard.
// Ports:
//   clk    - pipeline clock, rising edge
//   rst_n  - asynchronous active-low reset; forces all outputs to 0
//   io_hz  - hazard_stall_ctrl_if.slave: hazard inputs, control outputs
// Parameters: MC_TIMEOUT (>=2) max MC_WAIT cycles, PERF_W perf counter width.
// Optional: define HAZ_PERF_EN to enable saturating stall/flush perf counters;
//           otherwise the perf outputs are tied to 0.
module hazard_stall_ctrl #(
   parameter int MC_TIMEOUT = 64,
   parameter int PERF_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hazard_stall_ctrl_if.slave   io_hz
);
   localparam int CNT_W = $clog2(MC_TIMEOUT + 1);

   typedef enum logic [0:0] {S_RUN = 1'b0, S_MC_WAIT = 1'b1} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mc_err;

   logic w_rs1_ex, w_rs2_ex, w_rs1_mem;
   logic w_lu, w_jh, w_release;
   logic w_pc_stall, w_if_id_stall, w_id_ex_stall;
   logic w_if_id_flush, w_id_ex_flush, w_ex_mem_bubble, w_mc_start;

   // x0 is never a real dependency, so every match requires a nonzero source
   assign w_rs1_ex  = (io_hz.id_rs1 != 5'd0) && (io_hz.id_rs1 == io_hz.ex_rd);
   assign w_rs2_ex  = (io_hz.id_rs2 != 5'd0) && (io_hz.id_rs2 == io_hz.ex_rd);
   assign w_rs1_mem = (io_hz.id_rs1 != 5'd0) && (io_hz.id_rs1 == io_hz.mem_rd);

   assign w_lu = io_hz.ex_mem_read &
                 ((io_hz.id_use_rs1 & w_rs1_ex) | (io_hz.id_use_rs2 & w_rs2_ex));
   // JALR reads rs1 in ID: an ALU result in EX costs one stall; a load costs
   // two because the mem term re-arms once the load moves into MEM
   assign w_jh = io_hz.id_is_jalr &
                 ((io_hz.ex_reg_write & w_rs1_ex) | (io_hz.mem_mem_read & w_rs1_mem));

   // MC_WAIT releases on the done cycle (result latched this edge) or on timeout
   assign w_release = io_hz.mc_done || (r_cnt == CNT_W'(MC_TIMEOUT));

   always_comb begin
      w_pc_stall      = 1'b0;
      w_if_id_stall   = 1'b0;
      w_id_ex_stall   = 1'b0;
      w_if_id_flush   = 1'b0;
      w_id_ex_flush   = 1'b0;
      w_ex_mem_bubble = 1'b0;
      w_mc_start      = 1'b0;
      // outputs follow reset asynchronously, not just the next edge
      if (rst_n) begin
         if (r_state == S_RUN) begin
            if (io_hz.ex_br_taken) begin
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
            end else if (io_hz.ex_mc_req) begin
               w_mc_start      = 1'b1;
               w_pc_stall      = 1'b1;
               w_if_id_stall   = 1'b1;
               w_id_ex_stall   = 1'b1;
               w_ex_mem_bubble = 1'b1;
            end else if (w_lu || w_jh) begin
               w_pc_stall    = 1'b1;
               w_if_id_stall = 1'b1;
               w_id_ex_flush = 1'b1;
            end else if (io_hz.id_jump) begin
               w_if_id_flush = 1'b1;
            end
         end else if (!w_release) begin
            // front end frozen; branch/jump/load-use are irrelevant while EX holds the mc op
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_stall   = 1'b1;
            w_ex_mem_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_RUN;
         r_cnt    <= '0;
         r_mc_err <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (!io_hz.ex_br_taken && io_hz.ex_mc_req) begin
                  r_state <= S_MC_WAIT;
                  r_cnt   <= CNT_W'(1);
               end
            end
            S_MC_WAIT: begin
               if (io_hz.mc_done) begin
                  r_state <= S_RUN;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_W'(MC_TIMEOUT)) begin
                  r_state  <= S_RUN;
                  r_cnt    <= '0;
                  r_mc_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= S_RUN;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign io_hz.pc_stall      = w_pc_stall;
   assign io_hz.if_id_stall   = w_if_id_stall;
   assign io_hz.id_ex_stall   = w_id_ex_stall;
   assign io_hz.if_id_flush   = w_if_id_flush;
   assign io_hz.id_ex_flush   = w_id_ex_flush;
   assign io_hz.ex_mem_bubble = w_ex_mem_bubble;
   assign io_hz.mc_start      = w_mc_start;
   assign io_hz.mc_err        = r_mc_err;

`ifdef HAZ_PERF_EN
   logic [PERF_W-1:0] r_perf_stall;
   logic [PERF_W-1:0] r_perf_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_stall <= '0;
         r_perf_flush <= '0;
      end else begin
         if (w_pc_stall && (r_perf_stall != {PERF_W{1'b1}}))
            r_perf_stall <= r_perf_stall + PERF_W'(1);
         if ((w_if_id_flush || w_id_ex_flush) && (r_perf_flush != {PERF_W{1'b1}}))
            r_perf_flush <= r_perf_flush + PERF_W'(1);
      end
   end

   assign io_hz.perf_stall_cyc = r_perf_stall;
   assign io_hz.perf_flush_cnt = r_perf_flush;
`else
   assign io_hz.perf_stall_cyc = {PERF_W{1'b0}};
   assign io_hz.perf_flush_cnt = {PERF_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl
// Output vector order: {pc_stall, if_id_stall, id_ex_stall, if_id_flush,
//                       id_ex_flush, ex_mem_bubble, mc_start, mc_err}
module tb_hazard_stall_ctrl;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   exp_stall_cnt;
   int   exp_flush_cnt;
   logic [7:0] sb[$];

   typedef struct packed {
      logic [4:0] id_rs1;
      logic [4:0] id_rs2;
      logic       id_use_rs1;
      logic       id_use_rs2;
      logic       id_is_jalr;
      logic [4:0] ex_rd;
      logic       ex_mem_read;
      logic       ex_reg_write;
      logic [4:0] mem_rd;
      logic       mem_mem_read;
      logic       ex_br_taken;
      logic       id_jump;
      logic       ex_mc_req;
      logic       mc_done;
   } stim_t;

   hazard_stall_ctrl_if #(.PERF_W(32)) hz();

   hazard_stall_ctrl #(.MC_TIMEOUT(8), .PERF_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io_hz (hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply(input stim_t s);
      hz.id_rs1       = s.id_rs1;
      hz.id_rs2       = s.id_rs2;
      hz.id_use_rs1   = s.id_use_rs1;
      hz.id_use_rs2   = s.id_use_rs2;
      hz.id_is_jalr   = s.id_is_jalr;
      hz.ex_rd        = s.ex_rd;
      hz.ex_mem_read  = s.ex_mem_read;
      hz.ex_reg_write = s.ex_reg_write;
      hz.mem_rd       = s.mem_rd;
      hz.mem_mem_read = s.mem_mem_read;
      hz.ex_br_taken  = s.ex_br_taken;
      hz.id_jump      = s.id_jump;
      hz.ex_mc_req    = s.ex_mc_req;
      hz.mc_done      = s.mc_done;
   endtask

   function automatic logic [7:0] outs();
      return {hz.pc_stall, hz.if_id_stall, hz.id_ex_stall, hz.if_id_flush,
              hz.id_ex_flush, hz.ex_mem_bubble, hz.mc_start, hz.mc_err};
   endfunction

   // ex lw x5 with id reading x5 on rs1 (and x1 on rs2)
   function automatic stim_t lu_stim();
      stim_t s = '0;
      s.ex_mem_read = 1'b1; s.ex_reg_write = 1'b1; s.ex_rd = 5'd5;
      s.id_rs1 = 5'd5; s.id_use_rs1 = 1'b1; s.id_rs2 = 5'd1; s.id_use_rs2 = 1'b1;
      return s;
   endfunction

   task automatic test_reset();
      stim_t s = '0;
      logic [7:0] got;
      s.ex_mc_req = 1'b1; s.ex_br_taken = 1'b1;
      rst_n = 1'b0;
      apply(s);
      repeat (2) @(posedge clk);
      @(negedge clk);
      got = outs();
      checks++;
      if (got !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs got %b exp %b", got, 8'h00);
      end
      checks++;
      if (hz.perf_stall_cyc !== 32'd0 || hz.perf_flush_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_perf got %0d/%0d exp 0/0", hz.perf_stall_cyc, hz.perf_flush_cnt);
      end
      @(posedge clk); #1;
      apply('0);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_load_use();
      stim_t st[$]; logic [7:0] ex[$]; stim_t s; logic [7:0] got, e;
      st.push_back(lu_stim()); ex.push_back(8'b1100_1000);
      s = '0; s.id_rs1 = 5'd5; s.id_use_rs1 = 1'b1; s.id_rs2 = 5'd1; s.id_use_rs2 = 1'b1;
      s.mem_rd = 5'd5; s.mem_mem_read = 1'b1;
      st.push_back(s); ex.push_back(8'b0000_0000);
      s = lu_stim(); s.id_rs1 = 5'd7; s.id_rs2 = 5'd5;
      st.push_back(s); ex.push_back(8'b1100_1000);
      s = lu_stim(); s.id_use_rs1 = 1'b0;
      st.push_back(s); ex.push_back(8'b0000_0000);
      s = lu_stim(); s.ex_rd = 5'd0; s.id_rs1 = 5'd0;
      st.push_back(s); ex.push_back(8'b0000_0000);
      foreach (st[i]) begin
         apply(st[i]); sb.push_back(ex[i]);
         @(negedge clk);
         got = outs(); e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL load_use[%0d] got %b exp %b", i, got, e);
         end
         if (e[7]) exp_stall_cnt++;
         if (e[4] | e[3]) exp_flush_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_jalr();
      stim_t st[$]; logic [7:0] ex[$]; stim_t s; logic [7:0] got, e;
      s = '0; s.id_is_jalr = 1'b1; s.id_use_rs1 = 1'b1; s.id_rs1 = 5'd5;
      s.ex_rd = 5'd5; s.ex_mem_read = 1'b1; s.ex_reg_write = 1'b1;
      st.push_back(s); ex.push_back(8'b1100_1000);
      s.ex_rd = 5'd0; s.ex_mem_read = 1'b0; s.ex_reg_write = 1'b0;
      s.mem_rd = 5'd5; s.mem_mem_read = 1'b1;
      st.push_back(s); ex.push_back(8'b1100_1000);
      s.mem_rd = 5'd0; s.mem_mem_read = 1'b0; s.id_jump = 1'b1;
      st.push_back(s); ex.push_back(8'b0001_0000);
      s = '0; s.id_is_jalr = 1'b1; s.id_use_rs1 = 1'b1; s.id_rs1 = 5'd5;
      s.ex_rd = 5'd5; s.ex_reg_write = 1'b1;
      st.push_back(s); ex.push_back(8'b1100_1000);
      s.ex_rd = 5'd0; s.ex_reg_write = 1'b0; s.mem_rd = 5'd5; s.id_jump = 1'b1;
      st.push_back(s); ex.push_back(8'b0001_0000);
      foreach (st[i]) begin
         apply(st[i]); sb.push_back(ex[i]);
         @(negedge clk);
         got = outs(); e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL jalr[%0d] got %b exp %b", i, got, e);
         end
         if (e[7]) exp_stall_cnt++;
         if (e[4] | e[3]) exp_flush_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mc_done();
      stim_t st[$]; logic [7:0] ex[$]; stim_t s; logic [7:0] got, e;
      s = '0; s.ex_mc_req = 1'b1;
      st.push_back(s); ex.push_back(8'b1110_0110);
      st.push_back(s); ex.push_back(8'b1110_0100);
      s = lu_stim(); s.ex_mc_req = 1'b1; s.ex_br_taken = 1'b1; s.id_jump = 1'b1;
      st.push_back(s); ex.push_back(8'b1110_0100);
      s = '0; s.ex_mc_req = 1'b1;
      st.push_back(s); ex.push_back(8'b1110_0100);
      s.mc_done = 1'b1;
      st.push_back(s); ex.push_back(8'b0000_0000);
      s = '0; s.mc_done = 1'b1;
      st.push_back(s); ex.push_back(8'b0000_0000);
      st.push_back('0); ex.push_back(8'b0000_0000);
      foreach (st[i]) begin
         apply(st[i]); sb.push_back(ex[i]);
         @(negedge clk);
         got = outs(); e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL mc_done[%0d] got %b exp %b", i, got, e);
         end
         if (e[7]) exp_stall_cnt++;
         if (e[4] | e[3]) exp_flush_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      stim_t st[$]; logic [7:0] ex[$]; stim_t s; logic [7:0] got, e;
      for (int k = 0; k < 2; k++) begin
         s = '0; s.ex_mc_req = 1'b1;
         st.push_back(s); ex.push_back(8'b1110_0110);
         s.mc_done = 1'b1;
         st.push_back(s); ex.push_back(8'b0000_0000);
      end
      st.push_back('0); ex.push_back(8'b0000_0000);
      foreach (st[i]) begin
         apply(st[i]); sb.push_back(ex[i]);
         @(negedge clk);
         got = outs(); e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL back_to_back[%0d] got %b exp %b", i, got, e);
         end
         if (e[7]) exp_stall_cnt++;
         if (e[4] | e[3]) exp_flush_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch_priority();
      stim_t st[$]; logic [7:0] ex[$]; stim_t s; logic [7:0] got, e;
      s = lu_stim(); s.ex_br_taken = 1'b1; s.id_jump = 1'b1; s.ex_mc_req = 1'b1;
      st.push_back(s); ex.push_back(8'b0001_1000);
      st.push_back('0); ex.push_back(8'b0000_0000);
      s = '0; s.id_jump = 1'b1;
      st.push_back(s); ex.push_back(8'b0001_0000);
      s = lu_stim(); s.id_jump = 1'b1;
      st.push_back(s); ex.push_back(8'b1100_1000);
      foreach (st[i]) begin
         apply(st[i]); sb.push_back(ex[i]);
         @(negedge clk);
         got = outs(); e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL branch_priority[%0d] got %b exp %b", i, got, e);
         end
         if (e[7]) exp_stall_cnt++;
         if (e[4] | e[3]) exp_flush_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      stim_t st[$]; logic [7:0] ex[$]; stim_t s; logic [7:0] got, e;
      int pe_s, pe_f;
      s = '0; s.ex_mc_req = 1'b1;
      st.push_back(s); ex.push_back(8'b1110_0110);
      for (int k = 1; k < 8; k++) begin
         st.push_back(s); ex.push_back(8'b1110_0100);
      end
      st.push_back(s); ex.push_back(8'b0000_0000);
      st.push_back('0); ex.push_back(8'b0000_0001);
      st.push_back(lu_stim()); ex.push_back(8'b1100_1001);
      st.push_back('0); ex.push_back(8'b0000_0001);
      foreach (st[i]) begin
         apply(st[i]); sb.push_back(ex[i]);
         @(negedge clk);
         got = outs(); e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL timeout[%0d] got %b exp %b", i, got, e);
         end
         if (e[7]) exp_stall_cnt++;
         if (e[4] | e[3]) exp_flush_cnt++;
         @(posedge clk); #1;
      end
`ifdef HAZ_PERF_EN
      pe_s = exp_stall_cnt; pe_f = exp_flush_cnt;
`else
      pe_s = 0; pe_f = 0;
`endif
      checks++;
      if (hz.perf_stall_cyc !== 32'(pe_s) || hz.perf_flush_cnt !== 32'(pe_f)) begin
         errors++;
         $display("FAIL perf_counts got %0d/%0d exp %0d/%0d",
                  hz.perf_stall_cyc, hz.perf_flush_cnt, pe_s, pe_f);
      end
   endtask

   task automatic test_async_reset();
      stim_t st[$]; logic [7:0] ex[$]; stim_t s; logic [7:0] got, e;
      s = '0; s.ex_mc_req = 1'b1;
      st.push_back(s); ex.push_back(8'b1110_0111);
      st.push_back(s); ex.push_back(8'b1110_0101);
      foreach (st[i]) begin
         apply(st[i]); sb.push_back(ex[i]);
         @(negedge clk);
         got = outs(); e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL async_reset_pre[%0d] got %b exp %b", i, got, e);
         end
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      got = outs();
      checks++;
      if (got !== 8'h00) begin
         errors++;
         $display("FAIL async_reset_immediate got %b exp %b", got, 8'h00);
      end
      exp_stall_cnt = 0; exp_flush_cnt = 0;
      @(negedge clk);
      checks++;
      if (hz.perf_stall_cyc !== 32'd0 || hz.perf_flush_cnt !== 32'd0) begin
         errors++;
         $display("FAIL async_reset_perf got %0d/%0d exp 0/0", hz.perf_stall_cyc, hz.perf_flush_cnt);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      st.delete(); ex.delete();
      st.push_back('0); ex.push_back(8'b0000_0000);
      st.push_back(lu_stim()); ex.push_back(8'b1100_1000);
      st.push_back('0); ex.push_back(8'b0000_0000);
      foreach (st[i]) begin
         apply(st[i]); sb.push_back(ex[i]);
         @(negedge clk);
         got = outs(); e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL async_reset_post[%0d] got %b exp %b", i, got, e);
         end
         if (e[7]) exp_stall_cnt++;
         if (e[4] | e[3]) exp_flush_cnt++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      checks = 0; errors = 0; exp_stall_cnt = 0; exp_flush_cnt = 0;
      test_reset();
      test_load_use();
      test_jalr();
      test_mc_done();
      test_back_to_back();
      test_branch_priority();
      test_timeout();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
